// File: rtl/enum_codec.sv
// Enumerative index<->codeword codec (weight-major order). Latency W+w+1 cycles; one request in flight, result held until out_ready.
// Decode mode exists only when ENUM_DECODE_EN is defined; otherwise every request is an encode.
module enum_codec #(
  parameter int NBIT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic [NBIT:0]               in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NBIT:0]               out_data,
  output logic [$clog2(NBIT+2)-1:0]   out_weight
);

  localparam int W  = NBIT + 1;
  localparam int WW = $clog2(NBIT + 2);
  localparam int PW = $clog2(W);

  typedef enum logic [2:0] {IDLE, WEIGHT, SCAN, BASE, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    r, r_nx;
  logic [W-1:0]    cw, cw_nx;
  logic [WW-1:0]   cnt, cnt_nx;
  logic [WW-1:0]   wgt, wgt_nx;
  logic [PW-1:0]   pos, pos_nx;
  logic [W-1:0]    coef_w, coef_p;
  logic            mode;

  // Pascal's triangle built row by row; every entry of rows 0..W fits in W bits.
  function automatic logic [W-1:0] binom(input int n, input int k);
    logic [W-1:0] row [0:W];
    logic [W-1:0] res;
    for (int i = 0; i <= W; i++) row[i] = '0;
    row[0] = W'(1);
    for (int i = 1; i <= W; i++) begin
      if (i <= n) begin
        for (int j = W; j >= 1; j--) row[j] = row[j] + row[j-1];
      end
    end
    res = '0;
    for (int i = 0; i <= W; i++) begin
      if (i == k) res = row[i];
    end
    return res;
  endfunction

`ifdef ENUM_DECODE_EN
  logic mode_nx;
`else
  logic unused_mode;
  assign unused_mode = in_mode;
  assign mode        = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    r_nx     = r;
    cw_nx    = cw;
    cnt_nx   = cnt;
    wgt_nx   = wgt;
    pos_nx   = pos;
`ifdef ENUM_DECODE_EN
    mode_nx  = mode;
`endif
    // Decode scan needs C(pos, j+1) because j counts bits seen before this one.
    coef_w   = binom(W, int'(cnt));
    coef_p   = binom(int'(pos), int'(cnt) + (mode ? 1 : 0));
    case (state)
      IDLE: begin
        if (in_valid) begin
          cnt_nx = '0;
          wgt_nx = '0;
`ifdef ENUM_DECODE_EN
          mode_nx = in_mode;
          if (in_mode) begin
            r_nx     = '0;
            cw_nx    = in_data;
            pos_nx   = '0;
            state_nx = SCAN;
          end else begin
            r_nx     = in_data;
            cw_nx    = '0;
            pos_nx   = PW'(W-1);
            state_nx = WEIGHT;
          end
`else
          r_nx     = in_data;
          cw_nx    = '0;
          pos_nx   = PW'(W-1);
          state_nx = WEIGHT;
`endif
        end
      end
      WEIGHT: begin
        if (r >= coef_w) begin
          r_nx   = r - coef_w;
          cnt_nx = cnt + 1'b1;
        end else begin
          wgt_nx   = cnt;
          state_nx = SCAN;
        end
      end
      SCAN: begin
`ifdef ENUM_DECODE_EN
        if (mode) begin
          if (cw[pos]) begin
            cnt_nx = cnt + 1'b1;
            r_nx   = r + coef_p;
          end
          if (pos == PW'(W-1)) begin
            wgt_nx   = cnt_nx;
            cnt_nx   = '0;
            state_nx = BASE;
          end else begin
            pos_nx = pos + 1'b1;
          end
        end else
`endif
        begin
          if (cnt != '0 && r >= coef_p) begin
            cw_nx[pos] = 1'b1;
            r_nx       = r - coef_p;
            cnt_nx     = cnt - 1'b1;
          end
          if (pos == '0) state_nx = DONE;
          else           pos_nx   = pos - 1'b1;
        end
      end
`ifdef ENUM_DECODE_EN
      BASE: begin
        if (cnt < wgt) r_nx = r + coef_w;
        if (cnt == wgt) state_nx = DONE;
        else            cnt_nx   = cnt + 1'b1;
      end
`endif
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r          <= '0;
      cw         <= '0;
      cnt        <= '0;
      wgt        <= '0;
      pos        <= '0;
      out_data   <= '0;
      out_weight <= '0;
`ifdef ENUM_DECODE_EN
      mode       <= 1'b0;
`endif
    end else begin
      r   <= r_nx;
      cw  <= cw_nx;
      cnt <= cnt_nx;
      wgt <= wgt_nx;
      pos <= pos_nx;
`ifdef ENUM_DECODE_EN
      mode <= mode_nx;
`endif
      if (state != DONE && state_nx == DONE) begin
        out_data   <= mode ? r_nx : cw_nx;
        out_weight <= wgt_nx;
      end
    end
  end

endmodule

// File: tb/tb_enum_codec.sv
// Directed + exhaustive bench for enum_codec (NBIT=8) with a scoreboard queue and a table-sort reference model.
module tb_enum_codec;

  localparam int NBIT = 8;
  localparam int W    = NBIT + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_mode = 1'b0;
  logic [8:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;
  logic [3:0] out_weight;

  typedef struct {
    logic [8:0] d;
    logic [3:0] w;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [8:0] enc_tab [0:511];
  logic [3:0] wt_tab  [0:511];
  bit         seen    [0:511];

  enum_codec #(.NBIT(NBIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_weight(out_weight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request, optionally pulses in_valid while busy and stalls out_ready in DONE.
  task automatic run_req(input logic m, input logic [8:0] d, input logic [8:0] exp_d,
                         input logic [3:0] exp_w, input int hold, input bit pulse,
                         output logic [8:0] obs_d, output logic [3:0] obs_w);
    exp_t e;
    int   lat;
    int   guard;
    sb.push_back('{d: exp_d, w: exp_w, lat: W + int'(exp_w) + 1});
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_mode  = m;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (pulse) begin
        check("busy_in_ready", in_ready, 0);
        in_valid = lat[0];
        in_data  = ~d;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("out_valid_timeout", out_valid, 1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      e = '{d: '0, w: '0, lat: 0};
    end else begin
      e = sb.pop_front();
    end
    check("latency", lat, e.lat);
    check("out_data", out_data, e.d);
    check("out_weight", out_weight, e.w);
    obs_d = out_data;
    obs_w = out_weight;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, e.d);
      check("hold_weight", out_weight, e.w);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [8:0] od;
    logic [3:0] ow;
    logic [3:0] prev_w;
    int         n;

    // Reference ordering: group by weight, ascending numeric value within a weight.
    n = 0;
    for (int w = 0; w <= W; w++) begin
      for (int v = 0; v < 512; v++) begin
        if ($countones(v) == w) begin
          enc_tab[n] = 9'(v);
          wt_tab[n]  = 4'(w);
          n++;
        end
      end
    end
    for (int i = 0; i < 512; i++) seen[i] = 1'b0;

    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_weight", out_weight, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(1'b0, 9'd0,   9'h000, 4'd0, 0, 1'b0, od, ow);
    run_req(1'b0, 9'd1,   9'h001, 4'd1, 0, 1'b0, od, ow);
    run_req(1'b0, 9'd9,   9'h100, 4'd1, 0, 1'b0, od, ow);
    run_req(1'b0, 9'd10,  9'h003, 4'd2, 0, 1'b0, od, ow);
    run_req(1'b0, 9'd45,  9'h180, 4'd2, 0, 1'b0, od, ow);
    run_req(1'b0, 9'd511, 9'h1FF, 4'd9, 0, 1'b0, od, ow);
`ifdef ENUM_DECODE_EN
    run_req(1'b1, 9'h180, 9'd45, 4'd2, 0, 1'b0, od, ow);
    run_req(1'b1, 9'h100, 9'd9,  4'd1, 0, 1'b0, od, ow);
    run_req(1'b1, 9'h000, 9'd0,  4'd0, 0, 1'b0, od, ow);
`endif

    // Back-pressure with in_valid pulses while busy, then confirm nothing was queued.
    run_req(1'b0, 9'd100, enc_tab[100], wt_tab[100], 5, 1'b1, od, ow);
    repeat (25) @(posedge clk);
    #1;
    check("no_phantom_valid", out_valid, 0);
    check("no_phantom_ready", in_ready, 1);

    // Reset in the middle of the encode SCAN phase.
    in_mode  = 1'b0;
    in_data  = 9'd511;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_req(1'b0, 9'd10, 9'h003, 4'd2, 0, 1'b0, od, ow);

    // Exhaustive encode against the model, plus permutation, monotone weight and round trip.
    prev_w = '0;
    for (int i = 0; i < 512; i++) begin
      run_req(1'b0, 9'(i), enc_tab[i], wt_tab[i], 0, 1'b0, od, ow);
      check("perm_unique", seen[od], 0);
      seen[od] = 1'b1;
      check("weight_monotone", ow >= prev_w, 1);
      prev_w = ow;
`ifdef ENUM_DECODE_EN
      run_req(1'b1, od, 9'(i), wt_tab[i], 0, 1'b0, od, ow);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
